data_mem_rmw_responder: RTL and testbench

//  Responder side of the data-memory load/store protocol: accepts word/half/byte requests from a

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_word_array.sv | 20 ++
 rtl/data_mem_rmw_responder.sv | 106 ++++++++++
 tb/tb_data_mem_rmw_responder.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared MemSize encodings, responder state enum and lane extract/merge helpers
package dmem_pkg;
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ERR, S_RD, S_WR, S_DONE, S_WAIT, S_RESP} state_e;
  function automatic logic is_legal(input logic [1:0] sz, input logic [1:0] lane);
    return sz == SZ_WORD ? lane == 2'b00 : sz == SZ_HALF ? !lane[0] : sz == SZ_BYTE;
  endfunction
  function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] lane, input logic sgn);
    logic [15:0] h;
    logic [7:0] b;
    h = lane[1] ? w[31:16] : w[15:0];
    b = 8'(w >> {lane, 3'b000});
    return sz == SZ_HALF ? {{16{sgn & h[15]}}, h} : sz == SZ_BYTE ? {{24{sgn & b[7]}}, b} : w;
  endfunction
  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [1:0] sz, input logic [1:0] lane);
    logic [31:0] m;
    m = (sz == SZ_HALF ? 32'h0000_ffff : 32'h0000_00ff) << {lane, 3'b000};
    return sz == SZ_WORD ? wd : (old & ~m) | ((wd << {lane, 3'b000}) & m);
  endfunction
endpackage

// File: rtl/dmem_word_array.sv
// dmem_word_array: 2**DEPTH_LOG2 x 32 storage, sync read (held when re=0), read-before-write
//  clk in | we/addr/wdata write port | re/addr read port | rdata_q registered read data
module dmem_word_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata_q
);
  logic [31:0] mem_q [2**DEPTH_LOG2];
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem_q[addr];
    if (we) mem_q[addr] <= wdata;
  end
endmodule

// File: rtl/data_mem_rmw_responder.sv
// data_mem_rmw_responder: valid/ready load/store responder over a word array, sub-word stores as RMW
//  Clk, Reset (sync, active-high)
//  ReqValid/ReqReady handshake with ReqWrite, ReqSigned, Address[11:0] (size/index/lane), WriteData
//  RespValid/RespReady handshake with ReadData (extended load data, 0 for stores) and RespErr
module data_mem_rmw_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic        ReqSigned,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic        RespValid,
  input  logic        RespReady,
  output logic [31:0] ReadData,
  output logic        RespErr
);
  localparam state_e S_POST = WAIT_STATES != 0 ? S_WAIT : S_RESP;
  state_e state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, arr_rdata;
  logic write_q, write_d, sgn_q, sgn_d, err_q, err_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] sz, lane;
  logic unused_addr;
  assign sz = addr_q[11:10];
  assign lane = addr_q[1:0];
  assign unused_addr = ^Address[31:12];
  assign ReqReady = state_q == S_IDLE && !Reset;
  assign RespValid = state_q == S_RESP;
  assign ReadData = RespValid ? rdata_q : '0;
  assign RespErr = RespValid & err_q;
  // Reset gates the write so a store caught mid-WR is never committed
  dmem_word_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk    (Clk),
    .we     (state_q == S_WR && !Reset),
    .re     (state_q == S_RD),
    .addr   (addr_q[DEPTH_LOG2+1:2]),
    .wdata  (lane_merge(arr_rdata, wdata_q, sz, lane)),
    .rdata_q(arr_rdata)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    sgn_d = sgn_q;
    rdata_d = rdata_q;
    err_d = err_q;
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE: if (ReqValid) begin
        state_d = S_CHECK;
        addr_d = Address[11:0];
        wdata_d = WriteData;
        write_d = ReqWrite;
        sgn_d = ReqSigned;
      end
      S_CHECK: state_d = !is_legal(sz, lane) ? S_ERR : (write_q && sz == SZ_WORD) ? S_WR : S_RD;
      S_ERR: begin
        rdata_d = '0;
        err_d = 1'b1;
        cnt_d = '0;
        state_d = S_POST;
      end
      S_RD: state_d = write_q ? S_WR : S_DONE;
      S_WR: state_d = S_DONE;
      // array access retired; register the response word before the optional wait
      S_DONE: begin
        rdata_d = write_q ? '0 : lane_extract(arr_rdata, sz, lane, sgn_q);
        err_d = 1'b0;
        cnt_d = '0;
        state_d = S_POST;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        state_d = cnt_q == 4'(WAIT_STATES - 1) ? S_RESP : S_WAIT;
      end
      S_RESP: state_d = RespReady ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
    addr_q <= addr_d;
    wdata_q <= wdata_d;
    write_q <= write_d;
    sgn_q <= sgn_d;
  end
endmodule

// File: tb/tb_data_mem_rmw_responder.sv
// tb_data_mem_rmw_responder: scoreboard bench for the load/store responder at WAIT_STATES 0 and 3
module tb_data_mem_rmw_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, req_valid, req_write, req_signed, resp_ready, sel;
  logic [31:0] addr, wdata;
  logic rdy0, vld0, err0, rdy1, vld1, err1;
  logic [31:0] rd0, rd1;
  logic cur_rdy, cur_vld, cur_err;
  logic [31:0] cur_rd;
  assign cur_rdy = sel ? rdy1 : rdy0;
  assign cur_vld = sel ? vld1 : vld0;
  assign cur_err = sel ? err1 : err0;
  assign cur_rd = sel ? rd1 : rd0;
  data_mem_rmw_responder #(.DEPTH_LOG2(8), .WAIT_STATES(0)) dut (
    .Clk(clk), .Reset(rst), .ReqValid(req_valid & !sel), .ReqReady(rdy0), .ReqWrite(req_write),
    .ReqSigned(req_signed), .Address(addr), .WriteData(wdata), .RespValid(vld0),
    .RespReady(resp_ready), .ReadData(rd0), .RespErr(err0)
  );
  data_mem_rmw_responder #(.DEPTH_LOG2(8), .WAIT_STATES(3)) dut_w (
    .Clk(clk), .Reset(rst), .ReqValid(req_valid & sel), .ReqReady(rdy1), .ReqWrite(req_write),
    .ReqSigned(req_signed), .Address(addr), .WriteData(wdata), .RespValid(vld1),
    .RespReady(resp_ready), .ReadData(rd1), .RespErr(err1)
  );
  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic w, input logic s, input logic [31:0] a, input logic [31:0] d);
    int g = 0;
    @(negedge clk);
    req_write = w;
    req_signed = s;
    addr = a;
    wdata = d;
    req_valid = 1'b1;
    while (!cur_rdy && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("req_ready", 32'(cur_rdy), 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask
  task automatic recv(input int hold);
    exp_t e;
    int lat = 0;
    logic [31:0] held;
    resp_ready = hold == 0;
    e = sb.pop_front();
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!cur_vld && lat < 60);
    check({e.tag, "_valid"}, 32'(cur_vld), 1);
    check({e.tag, "_data"}, cur_rd, e.data);
    check({e.tag, "_err"}, 32'(cur_err), 32'(e.err));
    check({e.tag, "_lat"}, 32'(lat), 32'(e.lat));
    held = cur_rd;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1 check("hold_valid", 32'(cur_vld), 1);
      check("hold_data", cur_rd, held);
      check("hold_ready", 32'(cur_rdy), 0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 check({e.tag, "_done"}, 32'(cur_vld), 0);
    check({e.tag, "_rdy_next"}, 32'(cur_rdy), 1);
  endtask
  task automatic txn(input string tag, input logic w, input logic s, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp_data, input logic exp_err,
                     input int lat, input int hold = 0);
    sb.push_back('{tag: tag, data: exp_data, err: exp_err, lat: lat});
    send(w, s, a, d);
    recv(hold);
  endtask
  initial begin
    sel = 1'b0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_signed = 1'b0;
    addr = '0;
    wdata = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("rst_ready", 32'(rdy0), 0);
    check("rst_valid", 32'(vld0), 0);
    check("rst_data", rd0, 0);
    check("rst_err", 32'(err0), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 check("ready_after_rst", 32'(rdy0), 1);
    txn("st64", 1, 0, 32'h064, 32'hAABBCCDD, 32'h0, 0, 3);
    txn("ld64", 0, 0, 32'h064, 32'h0, 32'hAABBCCDD, 0, 3);
    txn("ld64_hi", 0, 0, 32'hFFFFF064, 32'h0, 32'hAABBCCDD, 0, 3);
    txn("st68", 1, 0, 32'h068, 32'h11223344, 32'h0, 0, 3);
    txn("sh46a", 1, 0, 32'h46A, 32'h6767ABCD, 32'h0, 0, 4);
    txn("ld68", 0, 0, 32'h068, 32'h0, 32'hABCD3344, 0, 3);
    txn("lhs46a", 0, 1, 32'h46A, 32'h0, 32'hFFFFABCD, 0, 3);
    txn("lhu46a", 0, 0, 32'h46A, 32'h0, 32'h0000ABCD, 0, 3);
    txn("lhu468", 0, 0, 32'h468, 32'h0, 32'h00003344, 0, 3);
    txn("st6c", 1, 0, 32'h06C, 32'h0, 32'h0, 0, 3);
    txn("sb86d", 1, 0, 32'h86D, 32'h000000FF, 32'h0, 0, 4);
    txn("ld6c", 0, 0, 32'h06C, 32'h0, 32'h0000FF00, 0, 3);
    txn("lbs86d", 0, 1, 32'h86D, 32'h0, 32'hFFFFFFFF, 0, 3);
    txn("lbu86d", 0, 0, 32'h86D, 32'h0, 32'h000000FF, 0, 3);
    txn("err405", 0, 0, 32'h405, 32'h0, 32'h0, 1, 2);
    txn("err002", 0, 0, 32'h002, 32'h0, 32'h0, 1, 2);
    txn("errC00", 0, 0, 32'hC00, 32'h0, 32'h0, 1, 2);
    txn("err469st", 1, 0, 32'h469, 32'h5555EEEE, 32'h0, 1, 2);
    txn("ld68_kept", 0, 0, 32'h068, 32'h0, 32'hABCD3344, 0, 3);
    txn("bp", 0, 0, 32'h064, 32'h0, 32'hAABBCCDD, 0, 3, 10);
    txn("st70", 1, 0, 32'h070, 32'h12345678, 32'h0, 0, 3);
    send(1, 0, 32'h870, 32'h000000AA);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 check("abort_valid", 32'(vld0), 0);
    check("abort_ready", 32'(rdy0), 0);
    @(negedge clk) rst = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1 check("abort_novalid", 32'(vld0), 0);
    end
    txn("ld70", 0, 0, 32'h070, 32'h0, 32'h12345678, 0, 3);
    sel = 1'b1;
    txn("w_st74", 1, 0, 32'h074, 32'hDEADBEEF, 32'h0, 0, 6);
    txn("w_ld74", 0, 0, 32'h074, 32'h0, 32'hDEADBEEF, 0, 6);
    txn("w_sb875", 1, 0, 32'h875, 32'h0000005A, 32'h0, 0, 7);
    txn("w_ld74b", 0, 0, 32'h074, 32'h0, 32'hDEAD5AEF, 0, 6);
    txn("w_err405", 0, 0, 32'h405, 32'h0, 32'h0, 1, 5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
